// File: rtl/serial_sub.sv
// Digit-serial subtractor dif = a - b - bin, DIGIT bits/clock LSB first; done STEPS+1 cycles after accept.
// start is honoured only while ready (IDLE); optional zero/ovf flags under SERIAL_SUB_FLAGS_EN.
module serial_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] dif,
   output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_sub: illegal WIDTH/DIGIT combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_nx;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   slice;
   logic [DIGIT-1:0] d;
   logic             d_b;
   logic             last;

   // One extra bit on the slice so its MSB is the borrow into the next digit.
   always_comb begin
      slice = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
   end

   assign d      = slice[DIGIT-1:0];
   assign d_b    = slice[DIGIT];
   assign res_nx = (res_sh >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
   assign last   = (cnt == CW'(STEPS - 1));

`ifdef SERIAL_SUB_FLAGS_EN
   logic msb_brw_in;
   logic ovf_nx;

   // On the last step the slice holds the top digit, so the borrow into the MSB is recoverable here.
   assign msb_brw_in = d[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
   assign ovf_nx     = msb_brw_in ^ d_b;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:    ready = 1'b1;
         DONE:    done  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         dif    <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
         zero   <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  brw    <= bin;
                  res_sh <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_nx;
               brw    <= d_b;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  dif  <= res_nx;
                  bout <= d_b;
`ifdef SERIAL_SUB_FLAGS_EN
                  zero <= (res_nx == '0);
                  ovf  <= ovf_nx;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8) share operands, separate starts.
module tb_serial_sub;

   typedef struct packed {
      logic [7:0] dif;
      logic       bout;
      logic       zero;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start4;
   logic [7:0] a, b;
   logic       bin;
   logic       rdy1, dn1, bo1, rdy4, dn4, bo4;
   logic [7:0] dif1, dif4;
   logic       z1, v1, z4, v4;

   int   n_chk = 0;
   int   n_err = 0;
   int   n_done1 = 0;
   int   n_done4 = 0;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
      .ready(rdy1), .done(dn1), .dif(dif1), .bout(bo1)
`ifdef SERIAL_SUB_FLAGS_EN
      , .zero(z1), .ovf(v1)
`endif
   );

   serial_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
      .ready(rdy4), .done(dn4), .dif(dif4), .bout(bo4)
`ifdef SERIAL_SUB_FLAGS_EN
      , .zero(z4), .ovf(v4)
`endif
   );

`ifndef SERIAL_SUB_FLAGS_EN
   assign z1 = 1'b0;
   assign v1 = 1'b0;
   assign z4 = 1'b0;
   assign v4 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
      exp_t e;
      int   du, ds;
      du     = int'(ma) - int'(mb) - int'(mbin);
      ds     = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      e.dif  = du[7:0];
      e.bout = (du < 0);
      e.zero = (du[7:0] == 8'h00);
      e.ovf  = (ds < -128) || (ds > 127);
      return e;
   endfunction

   // Scoreboard: push on the cycle an accept is pending, pop and compare on done.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rdy1 && start1) q1.push_back(model(a, b, bin));
      if (!rst && rdy4 && start4) q4.push_back(model(a, b, bin));
      if (dn1) begin
         n_done1++;
         if (q1.size() == 0) check("d1_unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            check("d1_dif", dif1, e.dif);
            check("d1_bout", bo1, e.bout);
`ifdef SERIAL_SUB_FLAGS_EN
            check("d1_zero", z1, e.zero);
            check("d1_ovf", v1, e.ovf);
`endif
         end
      end
      if (dn4) begin
         n_done4++;
         if (q4.size() == 0) check("d4_unexpected_done", 1, 0);
         else begin
            e = q4.pop_front();
            check("d4_dif", dif4, e.dif);
            check("d4_bout", bo4, e.bout);
`ifdef SERIAL_SUB_FLAGS_EN
            check("d4_zero", z4, e.zero);
            check("d4_ovf", v4, e.ovf);
`endif
         end
      end
   end

   // Called at posedge+1 with the selected instance idle; returns at posedge+1 after it is idle again.
   task automatic op(input bit w4, input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                     input int steps);
      int lat, busy;
      a = oa; b = ob; bin = obin;
      if (w4) start4 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
      lat = -1; busy = 0;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         if (!(w4 ? rdy4 : rdy1)) busy++;
         if (w4 ? dn4 : dn1) lat = k - 1;
      end
      check("latency", lat, steps);
      check("ready_low_cycles", busy, steps + 1);
      @(negedge clk);
      check("done_single_pulse", w4 ? dn4 : dn1, 0);
      check("ready_back", w4 ? rdy4 : rdy1, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int nd;
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready1", rdy1, 1);
      check("rst_done1", dn1, 0);
      check("rst_dif1", dif1, 0);
      check("rst_bout1", bo1, 0);
      check("rst_ready4", rdy4, 1);
      check("rst_dif4", dif4, 0);
      @(posedge clk); #1;

      op(0, 8'h5A, 8'h3C, 1'b0, 8);
      op(0, 8'h00, 8'h01, 1'b0, 8);
      op(0, 8'h00, 8'hFF, 1'b1, 8);
      op(0, 8'h80, 8'h01, 1'b0, 8);
      op(0, 8'h7F, 8'h7F, 1'b0, 8);
      op(0, 8'hC3, 8'h3C, 1'b1, 8);

      // start while busy must be dropped
      nd = n_done1;
      a = 8'h10; b = 8'h01; bin = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a = 8'hFF; b = 8'hFF;
      repeat (2) @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (20) @(negedge clk);
      check("busy_start_one_done", n_done1 - nd, 1);
      check("busy_start_ready", rdy1, 1);
      check("busy_start_queue_empty", q1.size(), 0);
      check("busy_start_dif_hold", dif1, 8'h0F);
      @(posedge clk); #1;

      // reset on the 4th RUN cycle aborts the operation
      nd = n_done1;
      a = 8'h55; b = 8'h11; bin = 1'b0; start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      q1.delete();
      @(negedge clk);
      check("abort_ready", rdy1, 1);
      check("abort_done", dn1, 0);
      check("abort_dif", dif1, 0);
      check("abort_bout", bo1, 0);
      repeat (10) @(negedge clk);
      check("abort_no_done", n_done1 - nd, 0);
      @(posedge clk); #1;
      op(0, 8'h03, 8'h05, 1'b0, 8);

      // DIGIT=4 with start held high: second accept only once ready returns
      op(1, 8'h22, 8'h33, 1'b0, 2);
      nd = n_done4;
      a = 8'hA3; b = 8'h5C; bin = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      a = 8'h10; b = 8'h20; bin = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("hold_ready_low", rdy4, 0);
      end
      check("hold_done_at_2", dn4, 1);
      @(negedge clk);
      check("hold_ready_back", rdy4, 1);
      @(posedge clk); #1 start4 = 1'b0;
      repeat (8) @(negedge clk);
      check("hold_two_dones", n_done4 - nd, 2);
      check("hold_queue_empty", q4.size(), 0);
      @(posedge clk); #1;
      op(1, 8'h00, 8'hFF, 1'b1, 2);
      op(1, 8'h80, 8'h01, 1'b0, 2);

      check("final_q1_empty", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Parametrised multi-cycle subtractor, the successor to the single-bit full subtractor. Computes dif = a - b - bin over WIDTH-bit operands, DIGIT bits per clock, LSB digit first, with a ripple borrow held in a register between cycles. Uses a start/ready/done handshake and sits in arithmetic datapaths where area matters more than latency, for example ALU slow paths and checksum units.

Parameters:
WIDTH  8  operand and result width in bits; must be ≥ 1
DIGIT  1  bits processed per clock; 1 ≤ DIGIT ≤ WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
STEPS  WIDTH/DIGIT  derived localparam; number of processing cycles

Ports:
clk    in   1      single clock, rising edge
rst    in   1      synchronous, active-high reset
start  in   1      request; sampled only when ready=1
a      in   WIDTH  minuend; sampled on the accepting edge
b      in   WIDTH  subtrahend; sampled on the accepting edge
bin    in   1      borrow-in; sampled on the accepting edge
ready  out  1      1 in IDLE only
done   out  1      one-cycle pulse when the result is valid
dif    out  WIDTH  result (a - b - bin) mod 2^WIDTH
bout   out  1      final borrow out; 1 iff a < b + bin (unsigned)

Behaviour:
- One clock (clk). rst is synchronous and active-high.
- Reset, checked on every edge and taking priority over everything else:
  - state=IDLE, ready=1, done=0, dif=0, bout=0.
  - Internal shift registers, borrow register and counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: load a_sh←a, b_sh←b, brw←bin, res_sh←0, cnt←0; go to RUN.
- RUN:
  - ready=0.
  - Each edge takes the slice {d_b, d} = a_sh[DIGIT-1:0] - b_sh[DIGIT-1:0] - brw, computed at DIGIT+1 bits.
  - res_sh is shifted right by DIGIT with d entering at the MSB end; a_sh and b_sh are shifted right by DIGIT; brw←d_b; cnt←cnt+1.
  - On the edge where cnt==STEPS-1: go to DONE and register dif←final res_sh and bout←final brw.
- DONE:
  - done=1 for exactly one cycle, ready=0; go to IDLE on the next edge.
- Latency: if start is accepted on edge E0, done=1 in the cycle after edge E0+STEPS. For STEPS=1 this is the cycle after E0+1.
- Throughput: one operation per STEPS+2 cycles. ready returns high on the edge that ends DONE.
- dif and bout change only on entry to DONE or on reset. They hold their value through IDLE and through the next operation until that operation reaches DONE.
- start while ready=0 (RUN or DONE) is ignored and not queued. Changes on a, b or bin after acceptance have no effect.
- Reset in RUN or DONE aborts the operation: no done pulse, and outputs return to their reset values.
- Width rule: slice arithmetic is DIGIT+1 bits; the extra MSB of the slice result is the borrow for the next digit.
- DIGIT=1 reduces each step to dif_bit = a^b^brw and borrow = (~a&b) | (~(a^b)&brw).
- Boundaries:
  - a=b with bin=0 → dif=0, bout=0.
  - a=0, b=2^WIDTH-1, bin=1 → dif=0, bout=1 (wrap-around).

Optional Feature:
SERIAL_SUB_FLAGS_EN
- Defined: adds two output ports, zero (1 bit) and ovf (1 bit).
  - Both are registered together with dif and bout on entry to DONE, reset to 0, and held thereafter like dif.
  - zero = (final result == 0).
  - ovf = signed overflow = borrow into the MSB bit XOR the final borrow. Equivalently: a[MSB] != b[MSB] and result[MSB] != a[MSB], with bin included.
  - With DIGIT>1, the borrow into the MSB bit is computed inside the last slice.
- Undefined: ports zero and ovf do not exist and no flag logic is generated. All other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, bin=0, start pulsed → done 8 edges after acceptance, dif=0x1E, bout=0; ready low for exactly 9 cycles (RUN ×8 + DONE ×1).
- WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 → dif=0xFF, bout=1. Then a=0x00, b=0xFF, bin=1 → dif=0x00, bout=1 (zero=1 if flags enabled).
- WIDTH=8, DIGIT=4: a=0xA3, b=0x5C, bin=1 → done 2 edges after acceptance, dif=0x46, bout=0; start held high throughout → next operation accepted only when ready=1.
- Start while busy: accept a=0x10, b=0x01; assert start with a=0xFF, b=0xFF on cycle 3 of RUN → dif=0x0F, no second done pulse, ready=1 afterwards.
- Reset mid-RUN at cycle 4 → next cycle state IDLE, ready=1, done=0, dif=0, bout=0; a fresh operation (a=0x03, b=0x05) then gives dif=0xFE, bout=1.
- SERIAL_SUB_FLAGS_EN defined, WIDTH=8: a=0x80, b=0x01, bin=0 → dif=0x7F, ovf=1, zero=0. Then a=0x7F, b=0x7F → dif=0x00, zero=1, ovf=0.
